// File: rtl/id_stage_scoreboard.sv
// Instruction-decode stage: register file with write-through bypass, load-use scoreboard
// covering LOAD_LAT cycles of load latency, ID/EX pipeline register and a stall counter.
module id_stage_scoreboard #(
    parameter int LEN         = 32,
    parameter int NB_ADDR     = 5,
    parameter int NB_CTRL_EX  = 6,
    parameter int NB_CTRL_M   = 9,
    parameter int NB_CTRL_WB  = 2,
    parameter int MEMREAD_BIT = 1,
    parameter int LOAD_LAT    = 1,
    parameter int NB_CNT      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [LEN-1:0]        i_PC,
    input  logic [LEN-1:0]        i_instruction,
    input  logic [NB_CTRL_EX-1:0] i_ctrl_ex,
    input  logic [NB_CTRL_M-1:0]  i_ctrl_mem,
    input  logic [NB_CTRL_WB-1:0] i_ctrl_wb,
    input  logic                  i_uses_rs,
    input  logic                  i_uses_rt,
    input  logic [NB_ADDR-1:0]    i_dest_reg,
    input  logic                  i_flush,
    input  logic                  i_RegWrite,
    input  logic [NB_ADDR-1:0]    i_write_reg,
    input  logic [LEN-1:0]        i_write_data,
    output logic                  o_stall,
    output logic                  o_valid_ex,
    output logic [LEN-1:0]        o_PC,
    output logic [LEN-1:0]        o_read_data_1,
    output logic [LEN-1:0]        o_read_data_2,
    output logic [LEN-1:0]        o_imm_ext,
    output logic [NB_ADDR-1:0]    o_rs,
    output logic [NB_ADDR-1:0]    o_rt,
    output logic [NB_ADDR-1:0]    o_rd,
    output logic [NB_CTRL_EX-1:0] o_ctrl_ex_bus,
    output logic [NB_CTRL_M-1:0]  o_ctrl_mem_bus,
    output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
    output logic [NB_CNT-1:0]     o_stall_count
);
    localparam int NREG = 2 ** NB_ADDR;

    function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] cnt);
        return (&cnt) ? cnt : cnt + NB_CNT'(1);
    endfunction

    function automatic logic signed [LEN-1:0] sign_ext16(input logic signed [15:0] v);
        return LEN'(v);
    endfunction

    // ---- stage p0: decode, register read, hazard detection ----
    logic [NB_ADDR-1:0]    rs_p0, rt_p0;
    logic signed [15:0]    imm_p0;
    logic signed [LEN-1:0] imm_ext_p0;
    logic [LEN-1:0]        rd1_p0, rd2_p0;
    logic                  ld_p0, issue_p0, rs_hit_p0, rt_hit_p0;
    logic                  unused_opcode;

    logic [LEN-1:0]        regs [NREG];
    logic [LOAD_LAT-1:0]   sb_v;
    logic [NB_ADDR-1:0]    sb_reg [LOAD_LAT];

    assign rs_p0         = NB_ADDR'(i_instruction[25:21]);
    assign rt_p0         = NB_ADDR'(i_instruction[20:16]);
    assign imm_p0        = i_instruction[15:0];
    assign imm_ext_p0    = sign_ext16(imm_p0);
    assign ld_p0         = i_ctrl_mem[MEMREAD_BIT];
    assign unused_opcode = ^i_instruction[31:26];

    always_comb begin
        rd1_p0 = '0;
        rd2_p0 = '0;
        if (rs_p0 != '0)
            rd1_p0 = (i_RegWrite && i_write_reg == rs_p0) ? i_write_data : regs[rs_p0];
        if (rt_p0 != '0)
            rd2_p0 = (i_RegWrite && i_write_reg == rt_p0) ? i_write_data : regs[rt_p0];
    end

    always_comb begin
        rs_hit_p0 = 1'b0;
        rt_hit_p0 = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (sb_v[k] && sb_reg[k] == rs_p0) rs_hit_p0 = 1'b1;
            if (sb_v[k] && sb_reg[k] == rt_p0) rt_hit_p0 = 1'b1;
        end
    end

    // Flush wins over stall: a killed instruction must never hold the front end.
    assign o_stall  = i_valid & ~i_flush &
                      ((i_uses_rs & (rs_p0 != '0) & rs_hit_p0) |
                       (i_uses_rt & (rt_p0 != '0) & rt_hit_p0));
    assign issue_p0 = i_valid & ~i_flush & ~o_stall;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (i_RegWrite && i_write_reg != '0) begin
            regs[i_write_reg] <= i_write_data;
        end
    end

    // Entry k holds a load issued k+1 cycles ago; shifting continues through stalls.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sb_v <= '0;
            for (int k = 0; k < LOAD_LAT; k++) sb_reg[k] <= '0;
        end else begin
            for (int k = 1; k < LOAD_LAT; k++) begin
                sb_v[k]   <= sb_v[k-1];
                sb_reg[k] <= sb_reg[k-1];
            end
            if (issue_p0 && ld_p0 && i_dest_reg != '0) begin
                sb_v[0]   <= 1'b1;
                sb_reg[0] <= i_dest_reg;
            end else begin
                sb_v[0]   <= 1'b0;
                sb_reg[0] <= '0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        o_stall_count <= '0;
        else if (o_stall) o_stall_count <= sat_inc(o_stall_count);
    end

    // ---- stage p1: ID/EX register ----
    logic                  vld_p1;
    logic [LEN-1:0]        pc_p1, rd1_p1, rd2_p1;
    logic signed [LEN-1:0] imm_p1;
    logic [NB_ADDR-1:0]    rs_p1, rt_p1, rd_p1;
    logic [NB_CTRL_EX-1:0] ctrl_ex_p1;
    logic [NB_CTRL_M-1:0]  ctrl_mem_p1;
    logic [NB_CTRL_WB-1:0] ctrl_wb_p1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            rd1_p1      <= '0;
            rd2_p1      <= '0;
            imm_p1      <= '0;
            rs_p1       <= '0;
            rt_p1       <= '0;
            rd_p1       <= '0;
            ctrl_ex_p1  <= '0;
            ctrl_mem_p1 <= '0;
            ctrl_wb_p1  <= '0;
        end else if (issue_p0) begin
            vld_p1      <= 1'b1;
            pc_p1       <= i_PC;
            rd1_p1      <= rd1_p0;
            rd2_p1      <= rd2_p0;
            imm_p1      <= imm_ext_p0;
            rs_p1       <= rs_p0;
            rt_p1       <= rt_p0;
            rd_p1       <= i_dest_reg;
            ctrl_ex_p1  <= i_ctrl_ex;
            ctrl_mem_p1 <= i_ctrl_mem;
            ctrl_wb_p1  <= i_ctrl_wb;
        end else begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            rd1_p1      <= '0;
            rd2_p1      <= '0;
            imm_p1      <= '0;
            rs_p1       <= '0;
            rt_p1       <= '0;
            rd_p1       <= '0;
            ctrl_ex_p1  <= '0;
            ctrl_mem_p1 <= '0;
            ctrl_wb_p1  <= '0;
        end
    end

    assign o_valid_ex     = vld_p1;
    assign o_PC           = pc_p1;
    assign o_read_data_1  = rd1_p1;
    assign o_read_data_2  = rd2_p1;
    assign o_imm_ext      = imm_p1;
    assign o_rs           = rs_p1;
    assign o_rt           = rt_p1;
    assign o_rd           = rd_p1;
    assign o_ctrl_ex_bus  = ctrl_ex_p1;
    assign o_ctrl_mem_bus = ctrl_mem_p1;
    assign o_ctrl_wb_bus  = ctrl_wb_p1;

endmodule

// File: tb/tb_id_stage_scoreboard.sv
// Bench for id_stage_scoreboard: three instances (LOAD_LAT 1, 2, 3; the last with a 2-bit counter)
// share stimulus; a queue of expected ID/EX contents is checked whenever the selected instance issues.
module tb_id_stage_scoreboard;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [31:0] i_PC, i_instruction;
    logic [5:0]  i_ctrl_ex;
    logic [8:0]  i_ctrl_mem;
    logic [1:0]  i_ctrl_wb;
    logic        i_uses_rs, i_uses_rt, i_flush, i_RegWrite;
    logic [4:0]  i_dest_reg, i_write_reg;
    logic [31:0] i_write_data;

    logic        stall_o [3];
    logic        vex_o [3];
    logic [31:0] pc_o [3], d1_o [3], d2_o [3], imm_o [3];
    logic [4:0]  rs_o [3], rt_o [3], rd_o [3];
    logic [5:0]  cex_o [3];
    logic [8:0]  cmem_o [3];
    logic [1:0]  cwb_o [3];
    logic [15:0] cnt_o [3];

    always #5 i_clk = ~i_clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CW = (g == 2) ? 2 : 16;
        logic [CW-1:0] cnt;
        id_stage_scoreboard #(.LOAD_LAT(g + 1), .NB_CNT(CW)) dut (
            .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_PC(i_PC),
            .i_instruction(i_instruction), .i_ctrl_ex(i_ctrl_ex), .i_ctrl_mem(i_ctrl_mem),
            .i_ctrl_wb(i_ctrl_wb), .i_uses_rs(i_uses_rs), .i_uses_rt(i_uses_rt),
            .i_dest_reg(i_dest_reg), .i_flush(i_flush), .i_RegWrite(i_RegWrite),
            .i_write_reg(i_write_reg), .i_write_data(i_write_data),
            .o_stall(stall_o[g]), .o_valid_ex(vex_o[g]), .o_PC(pc_o[g]),
            .o_read_data_1(d1_o[g]), .o_read_data_2(d2_o[g]), .o_imm_ext(imm_o[g]),
            .o_rs(rs_o[g]), .o_rt(rt_o[g]), .o_rd(rd_o[g]),
            .o_ctrl_ex_bus(cex_o[g]), .o_ctrl_mem_bus(cmem_o[g]), .o_ctrl_wb_bus(cwb_o[g]),
            .o_stall_count(cnt)
        );
        assign cnt_o[g] = 16'(cnt);
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  cex;
        logic [8:0]  cmem;
        logic [1:0]  cwb;
        logic [31:0] d1, d2, imm;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mregs [32];
    int          sel;
    int          checks = 0;
    int          errors = 0;

    // Scoreboard pop: every issued instruction of the selected instance must match the queue head.
    always @(negedge i_clk) begin
        exp_t act, e;
        if (!i_rst && vex_o[sel]) begin
            act = {pc_o[sel], rs_o[sel], rt_o[sel], rd_o[sel], cex_o[sel], cmem_o[sel],
                   cwb_o[sel], d1_o[sel], d2_o[sel], imm_o[sel]};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got pc=%h, expected no issue", pc_o[sel]);
            end else begin
                e = q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL idex_fields pc=%h: got %h expected %h", e.pc, act, e);
                end
            end
        end
    end

    function automatic logic [31:0] rdreg(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (i_RegWrite && i_write_reg == r) return i_write_data;
        return mregs[r];
    endfunction

    task automatic idle();
        i_valid = 0; i_flush = 0; i_uses_rs = 0; i_uses_rt = 0; i_dest_reg = 0;
        i_PC = 0; i_instruction = 0; i_ctrl_ex = 0; i_ctrl_mem = 0; i_ctrl_wb = 0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        if (i_RegWrite && i_write_reg != 0) mregs[i_write_reg] = i_write_data;
        #1;
        i_RegWrite = 0;
    endtask

    task automatic do_reset();
        idle();
        i_RegWrite = 0; i_write_reg = 0; i_write_data = 0;
        i_rst = 1;
        q.delete();
        for (int i = 0; i < 32; i++) mregs[i] = 0;
        @(posedge i_clk);
        @(posedge i_clk);
        #1 i_rst = 0;
    endtask

    // Drive one instruction into ID and queue what ID/EX must hold once it issues.
    task automatic present(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [15:0] imm, input logic ld, input logic urs,
                           input logic urt, input logic [4:0] dest);
        exp_t e;
        i_valid = 1; i_flush = 0; i_PC = pc;
        i_instruction = {(ld ? 6'h23 : 6'h00), rs, rt, imm};
        i_ctrl_ex = pc[7:2]; i_ctrl_mem = {pc[8:2], ld, 1'b0}; i_ctrl_wb = {1'b1, ld};
        i_uses_rs = urs; i_uses_rt = urt; i_dest_reg = dest;
        e.pc = pc; e.rs = rs; e.rt = rt; e.rd = dest;
        e.cex = pc[7:2]; e.cmem = {pc[8:2], ld, 1'b0}; e.cwb = {1'b1, ld};
        e.d1 = rdreg(rs); e.d2 = rdreg(rt); e.imm = {{16{imm[15]}}, imm};
        q.push_back(e);
    endtask

    task automatic test_reset();
        idle();
        i_RegWrite = 0; i_write_reg = 0; i_write_data = 0;
        i_rst = 1;
        #2;
        present(32'h40, 5'd1, 5'd2, 16'h1, 1'b0, 1'b1, 1'b1, 5'd3);
        q.delete();
        @(posedge i_clk);
        @(negedge i_clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({vex_o[g], stall_o[g], pc_o[g], rd_o[g], cex_o[g], cmem_o[g], cwb_o[g], cnt_o[g]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: vex=%b stall=%b pc=%h cmem=%h cnt=%0d, expected all 0",
                         g, vex_o[g], stall_o[g], pc_o[g], cmem_o[g], cnt_o[g]);
            end
        end
        #1 i_rst = 0;
        idle();
        tick();
    endtask

    task automatic test_lat1_load_use();
        logic expv [3] = '{1'b0, 1'b1, 1'b0};
        do_reset(); sel = 0;
        present(32'h100, 5'd1, 5'd2, 16'h10, 1'b1, 1'b1, 1'b0, 5'd5);
        @(negedge i_clk); checks++;
        if (stall_o[0] !== 1'b0) begin errors++; $display("FAIL lat1_load_stall: got %b expected 0", stall_o[0]); end
        tick();
        present(32'h104, 5'd5, 5'd5, 16'h0, 1'b0, 1'b1, 1'b1, 5'd6);
        for (int c = 1; c < 3; c++) begin
            @(negedge i_clk); checks++;
            if (stall_o[0] !== expv[c]) begin
                errors++; $display("FAIL lat1_stall cyc%0d: got %b expected %b", c, stall_o[0], expv[c]);
            end
            if (c == 2) begin
                checks++;
                if ({vex_o[0], cex_o[0], cmem_o[0], cwb_o[0]} !== '0) begin
                    errors++;
                    $display("FAIL lat1_bubble: vex=%b ctrl=%h/%h/%h expected all 0", vex_o[0], cex_o[0], cmem_o[0], cwb_o[0]);
                end
            end
            tick();
        end
        idle();
        @(negedge i_clk); checks++;
        if (cnt_o[0] !== 16'd1) begin errors++; $display("FAIL lat1_count: got %0d expected 1", cnt_o[0]); end
        tick();
    endtask

    task automatic test_lat2_load_use();
        logic e1 [3] = '{1'b1, 1'b1, 1'b0};
        logic e2 [2] = '{1'b1, 1'b0};
        do_reset(); sel = 1;
        present(32'h200, 5'd0, 5'd0, 16'h4, 1'b1, 1'b0, 1'b0, 5'd5);
        tick();
        present(32'h204, 5'd5, 5'd1, 16'h0, 1'b0, 1'b1, 1'b1, 5'd6);
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk); checks++;
            if (stall_o[1] !== e1[c]) begin errors++; $display("FAIL lat2_dep_stall cyc%0d: got %b expected %b", c, stall_o[1], e1[c]); end
            tick();
        end
        present(32'h208, 5'd0, 5'd0, 16'h8, 1'b1, 1'b0, 1'b0, 5'd5);
        tick();
        present(32'h20C, 5'd1, 5'd2, 16'hFFFF, 1'b0, 1'b1, 1'b1, 5'd7);
        @(negedge i_clk); checks++;
        if (stall_o[1] !== 1'b0) begin errors++; $display("FAIL lat2_indep_stall: got %b expected 0", stall_o[1]); end
        tick();
        present(32'h210, 5'd0, 5'd5, 16'h0, 1'b0, 1'b0, 1'b1, 5'd8);
        for (int c = 0; c < 2; c++) begin
            @(negedge i_clk); checks++;
            if (stall_o[1] !== e2[c]) begin errors++; $display("FAIL lat2_gap_stall cyc%0d: got %b expected %b", c, stall_o[1], e2[c]); end
            tick();
        end
        idle();
        @(negedge i_clk); checks++;
        if (cnt_o[1] !== 16'd3) begin errors++; $display("FAIL lat2_count: got %0d expected 3", cnt_o[1]); end
        tick();
    endtask

    task automatic test_bypass();
        do_reset(); sel = 0;
        i_RegWrite = 1; i_write_reg = 5'd7; i_write_data = 32'hDEADBEEF;
        present(32'h300, 5'd7, 5'd0, 16'h8001, 1'b0, 1'b1, 1'b0, 5'd8);
        tick();
        i_RegWrite = 1; i_write_reg = 5'd0; i_write_data = 32'h1234;
        present(32'h304, 5'd0, 5'd7, 16'h7FFF, 1'b0, 1'b1, 1'b1, 5'd9);
        @(negedge i_clk); checks++;
        if (d1_o[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rd1: got %h expected deadbeef", d1_o[0]); end
        tick();
        present(32'h308, 5'd0, 5'd0, 16'h0, 1'b0, 1'b1, 1'b1, 5'd10);
        @(negedge i_clk); checks++;
        if (d2_o[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL regfile_rd2: got %h expected deadbeef", d2_o[0]); end
        tick();
        idle();
        @(negedge i_clk); checks++;
        if (d1_o[0] !== 32'h0) begin errors++; $display("FAIL r0_read: got %h expected 0", d1_o[0]); end
        tick();
    endtask

    task automatic test_flush();
        do_reset(); sel = 1;
        present(32'h400, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, 1'b0, 5'd3);
        tick();
        i_valid = 1; i_flush = 1; i_PC = 32'h404; i_instruction = {6'h0, 5'd3, 5'd0, 16'h0};
        i_uses_rs = 1; i_uses_rt = 0; i_dest_reg = 5'd4;
        i_ctrl_ex = 6'h3F; i_ctrl_mem = 9'h1FF; i_ctrl_wb = 2'b11;
        @(negedge i_clk); checks++;
        if (stall_o[1] !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", stall_o[1]); end
        tick();
        present(32'h408, 5'd3, 5'd0, 16'h0, 1'b0, 1'b1, 1'b0, 5'd4);
        @(negedge i_clk); checks++;
        if ({vex_o[1], cex_o[1], cmem_o[1], cwb_o[1], cnt_o[1]} !== '0) begin
            errors++;
            $display("FAIL flush_bubble: vex=%b ctrl=%h/%h/%h cnt=%0d expected all 0", vex_o[1], cex_o[1], cmem_o[1], cwb_o[1], cnt_o[1]);
        end
        checks++;
        if (stall_o[1] !== 1'b1) begin errors++; $display("FAIL flush_next_stall: got %b expected 1", stall_o[1]); end
        tick();
        @(negedge i_clk); checks++;
        if (stall_o[1] !== 1'b0) begin errors++; $display("FAIL flush_next_release: got %b expected 0", stall_o[1]); end
        tick();
        idle();
        @(negedge i_clk); checks++;
        if (cnt_o[1] !== 16'd1) begin errors++; $display("FAIL flush_count: got %0d expected 1", cnt_o[1]); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset(); sel = 2;
        present(32'h500, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, 1'b0, 5'd4);
        tick();
        present(32'h504, 5'd4, 5'd0, 16'h2, 1'b0, 1'b1, 1'b0, 5'd11);
        tick();
        @(negedge i_clk); checks++;
        if (stall_o[2] !== 1'b1 || cnt_o[2] !== 16'd1) begin
            errors++; $display("FAIL midstall_pre: stall=%b cnt=%0d expected 1/1", stall_o[2], cnt_o[2]);
        end
        #2 i_rst = 1;
        #1; checks++;
        if ({stall_o[2], vex_o[2], pc_o[2], rd_o[2], cmem_o[2], cnt_o[2]} !== '0) begin
            errors++; $display("FAIL midstall_reset: stall=%b vex=%b cnt=%0d expected 0", stall_o[2], vex_o[2], cnt_o[2]);
        end
        @(posedge i_clk);
        #1 i_rst = 0;
        @(negedge i_clk); checks++;
        if (stall_o[2] !== 1'b0) begin errors++; $display("FAIL midstall_after: got %b expected 0", stall_o[2]); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_saturate();
        logic e1 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic e2 [3] = '{1'b1, 1'b1, 1'b0};
        do_reset(); sel = 2;
        present(32'h600, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, 1'b0, 5'd9);
        tick();
        present(32'h604, 5'd9, 5'd0, 16'h0, 1'b0, 1'b1, 1'b0, 5'd12);
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk); checks++;
            if (stall_o[2] !== e1[c]) begin errors++; $display("FAIL sat_stall_a cyc%0d: got %b expected %b", c, stall_o[2], e1[c]); end
            tick();
        end
        present(32'h608, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, 1'b0, 5'd10);
        @(negedge i_clk); checks++;
        if (cnt_o[2] !== 16'd3) begin errors++; $display("FAIL sat_reach: got %0d expected 3", cnt_o[2]); end
        tick();
        present(32'h60C, 5'd1, 5'd2, 16'h0, 1'b0, 1'b0, 1'b0, 5'd13);
        tick();
        present(32'h610, 5'd0, 5'd10, 16'h0, 1'b0, 1'b0, 1'b1, 5'd14);
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk); checks++;
            if (stall_o[2] !== e2[c]) begin errors++; $display("FAIL sat_stall_b cyc%0d: got %b expected %b", c, stall_o[2], e2[c]); end
            tick();
        end
        idle();
        @(negedge i_clk); checks++;
        if (cnt_o[2] !== 16'd3) begin errors++; $display("FAIL sat_hold: got %0d expected 3", cnt_o[2]); end
        tick();
    endtask

    task automatic test_r0();
        do_reset(); sel = 0;
        present(32'h700, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, 1'b0, 5'd0);
        tick();
        present(32'h704, 5'd0, 5'd0, 16'h0, 1'b0, 1'b1, 1'b1, 5'd1);
        @(negedge i_clk); checks++;
        if (stall_o[0] !== 1'b0) begin errors++; $display("FAIL r0_load_dest: got %b expected 0", stall_o[0]); end
        tick();
        present(32'h708, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, 1'b0, 5'd5);
        tick();
        present(32'h70C, 5'd0, 5'd0, 16'h0, 1'b0, 1'b1, 1'b1, 5'd2);
        @(negedge i_clk); checks++;
        if (stall_o[0] !== 1'b0) begin errors++; $display("FAIL r0_consumer: got %b expected 0", stall_o[0]); end
        tick();
        idle();
        @(negedge i_clk); checks++;
        if (cnt_o[0] !== 16'd0) begin errors++; $display("FAIL r0_count: got %0d expected 0", cnt_o[0]); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic e1 [3] = '{1'b1, 1'b1, 1'b0};
        do_reset(); sel = 1;
        present(32'h800, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, 1'b0, 5'd5);
        tick();
        present(32'h804, 5'd1, 5'd0, 16'h4, 1'b1, 1'b1, 1'b0, 5'd6);
        @(negedge i_clk); checks++;
        if (stall_o[1] !== 1'b0) begin errors++; $display("FAIL b2b_second_load: got %b expected 0", stall_o[1]); end
        tick();
        present(32'h808, 5'd5, 5'd6, 16'h0, 1'b0, 1'b1, 1'b1, 5'd7);
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk); checks++;
            if (stall_o[1] !== e1[c]) begin errors++; $display("FAIL b2b_stall cyc%0d: got %b expected %b", c, stall_o[1], e1[c]); end
            tick();
        end
        idle();
        @(negedge i_clk); checks++;
        if (cnt_o[1] !== 16'd2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", cnt_o[1]); end
        tick();
    endtask

    initial begin
        sel = 0;
        test_reset();
        test_lat1_load_use();
        test_lat2_load_use();
        test_bypass();
        test_flush();
        test_reset_mid_stall();
        test_saturate();
        test_r0();
        test_back_to_back();
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL queue_drain: %0d entries left, expected 0", q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/id_stage_scoreboard.md
# id_stage_scoreboard

Parametrised instruction-decode stage with integrated ID/EX pipeline register, internal register file with write-through bypass, and a load-use scoreboard supporting a configurable load latency. It sits between the IF/ID register and the EX stage. Control decode is external: the control unit feeds its buses in the same cycle. The block generalises single-bubble load-use detection to LOAD_LAT cycles of load unavailability, and adds flush/stall priority and a stall statistics counter.

## Interface
- LEN, 32, datapath width
- NB_ADDR, 5, register address width; register file depth = 2**NB_ADDR
- NB_CTRL_EX, 6, EX control bus width
- NB_CTRL_M, 9, MEM control bus width
- NB_CTRL_WB, 2, WB control bus width
- MEMREAD_BIT, 1, index of MemRead inside the MEM control bus
- LOAD_LAT, 1, cycles a load result is unavailable to a following instruction (legal 1..3)
- NB_CNT, 16, stall counter width

- i_clk  in  1  clock, all state updates on the rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  IF/ID holds a valid instruction
- i_PC  in  LEN  PC of the instruction in ID
- i_instruction  in  LEN  instruction word
- i_ctrl_ex / i_ctrl_mem / i_ctrl_wb  in  NB_CTRL_EX / NB_CTRL_M / NB_CTRL_WB  control buses from the control unit
- i_uses_rs, i_uses_rt  in  1 each  instruction reads rs / rt
- i_dest_reg  in  NB_ADDR  destination register (0 = none)
- i_flush  in  1  kill the instruction in ID
- i_RegWrite, i_write_reg, i_write_data  in  1, NB_ADDR, LEN  write-back port
- o_stall  out  1  combinational; hold PC and IF/ID
- o_valid_ex  out  1  ID/EX holds a real instruction
- o_PC, o_read_data_1, o_read_data_2, o_imm_ext  out  LEN each  registered operands
- o_rs, o_rt, o_rd  out  NB_ADDR each  registered rs, rt, and destination (i_dest_reg)
- o_ctrl_ex_bus, o_ctrl_mem_bus, o_ctrl_wb_bus  out  bus widths  registered control
- o_stall_count  out  NB_CNT  saturating count of hazard bubbles

## Operation
- Fields: rs = instr[25:21], rt = instr[20:16]. o_imm_ext is instr[15:0] sign-extended to LEN.
- Register file:
  - Write on the rising edge when i_RegWrite and i_write_reg ≠ 0.
  - Register 0 always reads 0.
  - Same-cycle read of the register being written returns i_write_data (bypass).
  - All registers clear on reset.
- Scoreboard:
  - LOAD_LAT entries {v, reg}; entry k is a load issued k+1 cycles ago.
  - Every cycle, entries shift k→k+1 and entry LOAD_LAT-1 is discarded.
  - Entry 0 loads {1, i_dest_reg} when an instruction issues with i_ctrl_mem[MEMREAD_BIT] = 1 and i_dest_reg ≠ 0. Otherwise entry 0 loads {0, 0}.
- Hazard: o_stall = i_valid & ~i_flush & ((i_uses_rs & rs ≠ 0 & rs matches any valid entry) | (i_uses_rt & rt ≠ 0 & rt matches any valid entry)).
- Issue condition: i_valid & ~i_flush & ~o_stall. On issue, the ID/EX register captures all fields and o_valid_ex = 1.
- Bubble, on stall, flush, or ~i_valid:
  - o_valid_ex = 0 and all three control buses = 0.
  - Data fields are don't-care; the implementation drives them to 0.
- Priority: reset > flush > stall > issue. Flush suppresses o_stall in the same cycle.
- o_stall_count increments by 1 on each cycle with o_stall = 1 and holds at 2**NB_CNT-1. Flush bubbles and idle bubbles are not counted.

## Timing
- ID→EX latency: 1 cycle; outputs are registered, except o_stall.
- With a load issued in cycle t, a dependent instruction in ID:
  - at cycle t+1 stalls for LOAD_LAT cycles and issues at t+1+LOAD_LAT;
  - arriving at ID at t+j (j ≤ LOAD_LAT) stalls LOAD_LAT-j+1 cycles.
- Scoreboard shifts during stalls, so a stall always terminates within LOAD_LAT cycles.
- Reset (asynchronous, any time including mid-stall):
  - all outputs 0 and o_stall = 0;
  - scoreboard cleared, counter = 0, register file cleared.
- Back-to-back loads: each occupies its own entry; a consumer of either stalls until that entry retires.
- A load with i_dest_reg = 0, or a consumer using r0, never stalls.

## Test plan
- LOAD_LAT=1: load r5 at t, then add r6,r5,r5 → o_stall=1 for exactly 1 cycle, one bubble (o_valid_ex=0, controls 0), add issues at t+2; o_stall_count=1.
- LOAD_LAT=2: load r5, dependent immediately → 2 bubbles; with one independent instruction in between → dependent stalls 1 cycle; o_stall_count=3 total.
- Write r7=0xDEADBEEF via i_RegWrite while ID reads r7 → o_read_data_1=0xDEADBEEF next cycle; write to r0 with 0x1234 → later read of r0 returns 0.
- Load r3, then dependent with i_flush=1 in the stall cycle → o_stall=0, bubble issued, counter unchanged; the next instruction depending on r3 follows the normal stall rules.
- Assert i_rst mid-stall (LOAD_LAT=3, after 1 bubble) → all outputs 0 immediately; after release, the same dependent instruction issues without stalling.
- NB_CNT=2: force 5 hazard stall cycles → o_stall_count saturates at 3.
